memaccess_ctrl: RTL and testbench

MEMACCESS_CTRL -- requirements
Module: memaccess_ctrl

---
 rtl/memaccess_ctrl.sv | 138 +++++++++++++
 tb/tb_memaccess_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memaccess_ctrl.sv
// rtl/memaccess_ctrl.sv - direct/indirect load-store controller with per-phase ack timeout
module memaccess_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              DMem_en,
    output logic              DMem_rd,
    output logic [ADDR_W-1:0] DMem_addr,
    output logic [DATA_W-1:0] DMem_din,
    input  logic [DATA_W-1:0] DMem_dout,
    input  logic              DMem_ack,
    output logic [DATA_W-1:0] memout,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PTR  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    // Counter value seen during the last cycle a phase may wait; an ack there still succeeds.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    logic [2:0]        state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wcnt;
    logic              timed_out;
    logic [ADDR_W-1:0] ptr_addr;
    logic              phase_timeout;

    generate
        if (DATA_W >= ADDR_W) begin : g_ptr_trunc
            assign ptr_addr = DMem_dout[ADDR_W-1:0];
        end else begin : g_ptr_zext
            assign ptr_addr = {{(ADDR_W-DATA_W){1'b0}}, DMem_dout};
        end
    endgenerate

    assign phase_timeout = !DMem_ack && (wcnt == LAST_WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_q    <= 2'b00;
            addr_q    <= '0;
            eff_addr  <= '0;
            wdata_q   <= '0;
            wcnt      <= 8'd0;
            timed_out <= 1'b0;
            memout    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        mode_q    <= req_mode;
                        addr_q    <= req_addr;
                        eff_addr  <= req_addr;
                        wdata_q   <= req_wdata;
                        wcnt      <= 8'd0;
                        timed_out <= 1'b0;
                        if (req_mode[0])      state <= S_PTR;
                        else if (req_mode[1]) state <= S_WR;
                        else                  state <= S_RD;
                    end
                end
                S_PTR: begin
                    if (DMem_ack) begin
                        eff_addr <= ptr_addr;
                        wcnt     <= 8'd0;
                        state    <= mode_q[1] ? S_WR : S_RD;
                    end else if (phase_timeout) begin
                        timed_out <= 1'b1;
                        state     <= S_FIN;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                S_RD, S_WR: begin
                    if (DMem_ack) begin
                        if (state == S_RD) memout <= DMem_dout;
                        state <= S_FIN;
                    end else if (phase_timeout) begin
                        timed_out <= 1'b1;
                        state     <= S_FIN;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                S_FIN: begin
                    wcnt  <= 8'd0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        done      = (state == S_FIN);
        err       = (state == S_FIN) && timed_out;
        DMem_en   = 1'b0;
        DMem_rd   = 1'b1;
        DMem_addr = '0;
        DMem_din  = '0;
        case (state)
            S_PTR: begin
                DMem_en   = 1'b1;
                DMem_addr = addr_q;
            end
            S_RD: begin
                DMem_en   = 1'b1;
                DMem_addr = eff_addr;
            end
            S_WR: begin
                DMem_en   = 1'b1;
                DMem_rd   = 1'b0;
                DMem_addr = eff_addr;
                DMem_din  = wdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memaccess_ctrl.sv
// tb/tb_memaccess_ctrl.sv - directed scoreboard bench for memaccess_ctrl
module tb_memaccess_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        DMem_en;
    logic        DMem_rd;
    logic [15:0] DMem_addr;
    logic [15:0] DMem_din;
    logic [15:0] DMem_dout;
    logic        DMem_ack;
    logic [15:0] memout;
    logic        done;
    logic        err;

    typedef struct packed {
        logic        err;
        logic [15:0] memout;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   en_cycles;

    memaccess_ctrl #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .DMem_en   (DMem_en),
        .DMem_rd   (DMem_rd),
        .DMem_addr (DMem_addr),
        .DMem_din  (DMem_din),
        .DMem_dout (DMem_dout),
        .DMem_ack  (DMem_ack),
        .memout    (memout),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic issue(input logic [1:0] mode, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic exp_err,
                         input logic [15:0] exp_mem);
        req_valid = 1'b1;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
        sb.push_back('{err: exp_err, memout: exp_mem});
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic do_phase(input logic exp_rd, input logic [15:0] exp_addr,
                            input logic [15:0] exp_din, input int delay,
                            input logic [15:0] rdata);
        chk("en", {31'd0, DMem_en}, 32'd1);
        chk("rd", {31'd0, DMem_rd}, {31'd0, exp_rd});
        chk("addr", {16'd0, DMem_addr}, {16'd0, exp_addr});
        chk("din", {16'd0, DMem_din}, {16'd0, exp_din});
        chk("ready_busy", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < delay; i++) @(negedge clock);
        DMem_ack  = 1'b1;
        DMem_dout = rdata;
        @(negedge clock);
        DMem_ack  = 1'b0;
        DMem_dout = 16'h0;
    endtask

    task automatic wait_done(input int budget, output int en_cnt);
        int n;
        exp_t e;
        n = 0;
        en_cnt = 0;
        while (!done && n < budget) begin
            if (DMem_en) en_cnt++;
            @(negedge clock);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("memout", {16'd0, memout}, {16'd0, e.memout});
            chk("en_in_fin", {31'd0, DMem_en}, 32'd0);
            @(negedge clock);
            chk("done_pulse", {31'd0, done}, 32'd0);
            chk("ready_after", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_mode  = 2'b00;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        DMem_dout = 16'h0;
        DMem_ack  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_en", {31'd0, DMem_en}, 32'd0);
        chk("rst_rd", {31'd0, DMem_rd}, 32'd1);
        chk("rst_addr", {16'd0, DMem_addr}, 32'd0);
        chk("rst_din", {16'd0, DMem_din}, 32'd0);
        chk("rst_memout", {16'd0, memout}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);

        // LOAD with ack one cycle into the phase
        issue(2'b00, 16'h3000, 16'h0, 1'b0, 16'hBEEF);
        do_phase(1'b1, 16'h3000, 16'h0, 1, 16'hBEEF);
        wait_done(4, en_cycles);

        // STORE_IND through pointer 0x5000
        issue(2'b11, 16'h4000, 16'h1234, 1'b0, 16'hBEEF);
        do_phase(1'b1, 16'h4000, 16'h0, 0, 16'h5000);
        do_phase(1'b0, 16'h5000, 16'h1234, 0, 16'hDEAD);
        wait_done(4, en_cycles);

        // LOAD that never gets an ack
        issue(2'b00, 16'h0100, 16'h0, 1'b1, 16'hBEEF);
        wait_done(40, en_cycles);
        chk("timeout_en_cycles", en_cycles, 32'd15);

        // LOAD_IND whose pointer ack lands on the final wait cycle
        issue(2'b01, 16'h0700, 16'h0, 1'b0, 16'hCAFE);
        do_phase(1'b1, 16'h0700, 16'h0, 14, 16'h0777);
        do_phase(1'b1, 16'h0777, 16'h0, 0, 16'hCAFE);
        wait_done(4, en_cycles);

        // Reset in the middle of a WR phase
        issue(2'b10, 16'h0200, 16'h55AA, 1'b0, 16'hCAFE);
        chk("wr_en", {31'd0, DMem_en}, 32'd1);
        chk("wr_rd", {31'd0, DMem_rd}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        sb.delete();
        chk("rst_wr_en", {31'd0, DMem_en}, 32'd0);
        chk("rst_wr_done", {31'd0, done}, 32'd0);
        chk("rst_wr_memout", {16'd0, memout}, 32'd0);
        reset = 1'b0;
        chk("rst_wr_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        chk("rst_wr_nodone", {31'd0, done}, 32'd0);
        issue(2'b00, 16'h0010, 16'h0, 1'b0, 16'h1111);
        do_phase(1'b1, 16'h0010, 16'h0, 2, 16'h1111);
        wait_done(4, en_cycles);

        // Spurious ack in IDLE
        DMem_ack  = 1'b1;
        DMem_dout = 16'hFFFF;
        @(negedge clock);
        DMem_ack  = 1'b0;
        DMem_dout = 16'h0;
        chk("spur_ready", {31'd0, req_ready}, 32'd1);
        chk("spur_done", {31'd0, done}, 32'd0);
        chk("spur_memout", {16'd0, memout}, 32'h1111);

        // Back-to-back with req_valid held high
        req_valid = 1'b1;
        req_mode  = 2'b00;
        req_addr  = 16'h0020;
        chk("b2b_ready_a", {31'd0, req_ready}, 32'd1);
        sb.push_back('{err: 1'b0, memout: 16'h4242});
        @(negedge clock);
        req_mode  = 2'b10;
        req_addr  = 16'h0030;
        req_wdata = 16'h9999;
        sb.push_back('{err: 1'b0, memout: 16'h4242});
        do_phase(1'b1, 16'h0020, 16'h0, 1, 16'h4242);
        chk("b2b_ready_fin", {31'd0, req_ready}, 32'd0);
        wait_done(4, en_cycles);
        @(negedge clock);
        req_valid = 1'b0;
        do_phase(1'b0, 16'h0030, 16'h9999, 0, 16'h0);
        wait_done(4, en_cycles);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
